axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 slave bridge between one crossbar slave port (IM/DM class) and a single-port, 1-cycle-latency SRAM macro.
//  Accepts one read or one write burst at a time, INCR word beats, 32-bit data, 8-bit slave-side IDs.
//  Converts each beat into one SRAM access and returns R/B responses under the full AXI valid/ready handshake.
// PARAMETERS
//  ID_W    8   AXI slave-side ID width (ARID/AWID/RID/BID)
//  ADDR_W  14  SRAM word-address width; the SRAM holds 2**ADDR_W 32-bit words
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/32/4/3/2   read address channel
//  ARVALID in 1 / ARREADY out 1      read address handshake
//  RID out ID_W, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1   read data channel
//  AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/32/4/3/2   write address channel
//  AWVALID in 1 / AWREADY out 1      write address handshake
//  WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1   write data channel
//  BID out ID_W, BRESP out 2, BVALID out 1, BREADY in 1              write response channel
//  sram_cs    out  1       SRAM access strobe, one access per asserted cycle
//  sram_we    out  4       per-byte write enable, active-high; 0 = read
//  sram_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2]
//  sram_wdata out  32      write data
//  sram_rdata in   32      read data, valid the cycle after a read strobe
// BEHAVIOUR
//  Reset: state IDLE; every output 0 while rst=1 (ARREADY/AWREADY low during reset); latched ID/addr/len/count cleared.
//  FSM: IDLE, R_WAIT, R_VALID, W_DATA, W_RESP.
//  IDLE: ARREADY=1; AWREADY=~ARVALID (read wins a same-cycle AR/AW tie; AW stays pending).
//   AR handshake: latch ARID/ARLEN, beat=0, sram_cs=1, sram_we=0, sram_addr=ARADDR word -> R_WAIT.
//   AW handshake: latch AWID/AWADDR, -> W_DATA.
//  R_WAIT: capture sram_rdata into RDATA register -> R_VALID.
//  R_VALID: RVALID=1, RID=latched ID, RLAST=(beat==len); RDATA/RID/RLAST stable until RREADY.
//   handshake & ~RLAST: beat+1, addr+1 word, issue next read same cycle -> R_WAIT.
//   handshake & RLAST -> IDLE. Latency AR handshake -> RVALID = 2 cycles; 2 cycles per beat minimum.
//  W_DATA: WREADY=1; each W handshake: sram_cs=1, sram_we=WSTRB, sram_wdata=WDATA, addr then +1 word.
//   WSTRB=0 beat still consumed, sram_cs=1 with we=0 (harmless read). WLAST handshake -> W_RESP.
//   Burst ends on WLAST only; beat count vs AWLEN not checked.
//  W_RESP: BVALID=1, BID=latched ID, BRESP held until BREADY; handshake -> IDLE (next AR/AW accepted next cycle).
//  Address: word increment, wraps modulo 2**ADDR_W (word 2**ADDR_W-1 -> 0); ARADDR/AWADDR[1:0] ignored; upper bits ignored.
//  ARLEN=0 single beat, RLAST on first beat; ARLEN=15 -> 16 beats.
//  No outstanding transactions: AR/AW not accepted outside IDLE.
//  Reset mid-burst: burst abandoned, no R/B response, no further SRAM access.
// CONFIGURATION
//  AXI_SRAM_SLVERR_EN defined: burst with SIZE!=3'b010 or BURST!=INCR flagged at address handshake;
//   read beats return RDATA=0, RRESP=SLVERR(2'b10), no sram_cs; write beats consumed with sram_cs=0, BRESP=SLVERR.
//  Not defined: SIZE/BURST ignored, all bursts handled as INCR word, RRESP/BRESP always OKAY.
// TESTING
//  Single read: mem[0x10]=0xDEADBEEF, ARADDR=0x40 LEN=0 ID=0x23 -> RVALID 2 cycles later, RDATA=0xDEADBEEF, RID=0x23, RLAST=1, RRESP=0.
//  Read burst with backpressure: LEN=3 from 0x0, RREADY low 3 cycles on beat 1 -> 4 beats in order, RDATA held stable, RLAST only on beat 3.
//  Write burst, strobes: AWADDR=0x8 LEN=1, WSTRB=4'b0011 then 4'b1111, mem pre=0xFFFFFFFF -> words 2,3 = {16'hFFFF,WDATA[15:0]}, WDATA; BVALID after WLAST, BID=AWID.
//  Tie + wrap: ARVALID&AWVALID same cycle -> read served first, AW accepted after RLAST; read from word 2**ADDR_W-1 LEN=1 -> second beat from word 0.
//  Reset mid-burst: rst=1 during R_VALID of beat 1 of LEN=3 -> RVALID=0, ARREADY=1 first cycle after release, no stale beats.
//  SLVERR_EN: ARSIZE=3'b001 -> RRESP=2'b10, RDATA=0, sram_cs never asserted; without macro same request -> OKAY, real data.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR-word burst slave driving a 1-cycle-latency single-port SRAM.
// Define AXI_SRAM_SLVERR_EN to answer non-word-size or non-INCR bursts with SLVERR.
module axi_sram_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   ARID,
    input  logic [31:0]       ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [ID_W-1:0]   AWID,
    input  logic [31:0]       AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic              sram_cs,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    typedef enum logic [2:0] {IDLE, R_WAIT, R_VALID, W_DATA, W_RESP} state_t;
    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [3:0]        len_q, len_d, beat_q, beat_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d, ar_err, aw_err, unused_ok;
    assign addr_inc = addr_q + ADDR_W'(1);
`ifdef AXI_SRAM_SLVERR_EN
    assign ar_err = (ARSIZE != 3'b010) || (ARBURST != 2'b01);
    assign aw_err = (AWSIZE != 3'b010) || (AWBURST != 2'b01);
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif
    // AWLEN is not tracked: write bursts end on WLAST alone
    assign unused_ok = ^{ARADDR[31:ADDR_W+2], ARADDR[1:0], AWADDR[31:ADDR_W+2], AWADDR[1:0],
                         ARSIZE, ARBURST, AWSIZE, AWBURST, AWLEN};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ARREADY    = 1'b0;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        RID        = '0;
        RDATA      = '0;
        RRESP      = 2'b00;
        RLAST      = 1'b0;
        RVALID     = 1'b0;
        BID        = '0;
        BRESP      = 2'b00;
        BVALID     = 1'b0;
        sram_cs    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        // every output is forced low while reset is held, even before the state register clears
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    ARREADY = 1'b1;
                    AWREADY = ~ARVALID;
                    if (ARVALID) begin
                        id_d      = ARID;
                        len_d     = ARLEN;
                        beat_d    = '0;
                        err_d     = ar_err;
                        addr_d    = ARADDR[ADDR_W+1:2];
                        sram_cs   = ~ar_err;
                        sram_addr = ARADDR[ADDR_W+1:2];
                        state_d   = R_WAIT;
                    end else if (AWVALID) begin
                        id_d    = AWID;
                        err_d   = aw_err;
                        addr_d  = AWADDR[ADDR_W+1:2];
                        state_d = W_DATA;
                    end
                end
                R_WAIT: begin
                    rdata_d = err_q ? '0 : sram_rdata;
                    state_d = R_VALID;
                end
                R_VALID: begin
                    RVALID = 1'b1;
                    RID    = id_q;
                    RDATA  = rdata_q;
                    RRESP  = err_q ? 2'b10 : 2'b00;
                    RLAST  = beat_q == len_q;
                    if (RREADY) begin
                        state_d = RLAST ? IDLE : R_WAIT;
                        if (!RLAST) begin
                            beat_d    = beat_q + 4'd1;
                            addr_d    = addr_inc;
                            sram_cs   = ~err_q;
                            sram_addr = addr_inc;
                        end
                    end
                end
                W_DATA: begin
                    WREADY = 1'b1;
                    if (WVALID) begin
                        sram_cs    = ~err_q;
                        sram_we    = err_q ? 4'b0000 : WSTRB;
                        sram_wdata = WDATA;
                        sram_addr  = addr_q;
                        addr_d     = addr_inc;
                        state_d    = WLAST ? W_RESP : W_DATA;
                    end
                end
                W_RESP: begin
                    BVALID  = 1'b1;
                    BID     = id_q;
                    BRESP   = err_q ? 2'b10 : 2'b00;
                    state_d = BREADY ? IDLE : W_RESP;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and randomized AXI bursts checked against a word-array memory model.
module tb_axi_sram_slave;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_W-1:0] ARID = '0, AWID = '0, RID, BID;
    logic [31:0] ARADDR = '0, AWADDR = '0, RDATA, WDATA = '0, sram_wdata;
    logic [3:0] ARLEN = '0, AWLEN = '0, WSTRB = '0, sram_we;
    logic [2:0] ARSIZE = 3'b010, AWSIZE = 3'b010;
    logic [1:0] ARBURST = 2'b01, AWBURST = 2'b01, RRESP, BRESP;
    logic ARVALID = 0, ARREADY, RLAST, RVALID, RREADY = 0, AWVALID = 0, AWREADY;
    logic WLAST = 0, WVALID = 0, WREADY, BVALID, BREADY = 0, sram_cs;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0] sram_rdata = '0;

    int compared = 0;
    int mismatched = 0;
    int cs_cnt = 0;
    logic [31:0] sram_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    function automatic bit is_err(input logic [2:0] sz, input logic [1:0] bt);
`ifdef AXI_SRAM_SLVERR_EN
        return (sz != 3'b010) || (bt != 2'b01);
`else
        return (sz == 3'b111) && (bt == 2'b11) && 1'b0;
`endif
    endfunction

    // SRAM macro: read data appears the cycle after the strobe
    initial begin
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (sram_cs) begin
                sram_rdata <= sram_mem[sram_addr];
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                cs_cnt <= cs_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] bt,
                           input int stall_beat, input int stall_n);
        bit err = is_err(sz, bt);
        logic [ADDR_W-1:0] w = a[ADDR_W+1:2];
        logic [31:0] exp;
        int n = 0;
        ARID = id; ARADDR = a; ARLEN = len; ARSIZE = sz; ARBURST = bt; ARVALID = 1; #1;
        while (!ARREADY && n < 50) begin tick; #1; n++; end
        check("arready", 32'(ARREADY), 1);
        if (AWVALID) check("aw_tie_blocked", 32'(AWREADY), 0);
        tick; ARVALID = 0; #1;
        check("r_latency_1", 32'(RVALID), 0);
        tick; #1;
        check("r_latency_2", 32'(RVALID), 1);
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!RVALID && n < 50) begin tick; #1; n++; end
            check("rvalid", 32'(RVALID), 1);
            exp = err ? 32'h0 : ref_mem[w];
            check("rdata", RDATA, exp);
            check("rid", 32'(RID), 32'(id));
            check("rlast", 32'(RLAST), 32'(i == int'(len)));
            check("rresp", 32'(RRESP), err ? 32'd2 : 32'd0);
            if (i == stall_beat)
                repeat (stall_n) begin
                    tick; #1;
                    check("rdata_hold", RDATA, exp);
                    check("rvalid_hold", 32'(RVALID), 1);
                end
            RREADY = 1; tick; RREADY = 0; #1;
            if (i < int'(len)) check("r_beat_gap", 32'(RVALID), 0);
            w++;
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] sz, input logic [1:0] bt);
        bit err = is_err(sz, bt);
        logic [ADDR_W-1:0] w = a[ADDR_W+1:2];
        int n = 0;
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt; AWVALID = 1; #1;
        while (!AWREADY && n < 50) begin tick; #1; n++; end
        check("awready", 32'(AWREADY), 1);
        tick; AWVALID = 0; #1;
        for (int i = 0; i <= int'(len); i++) begin
            repeat ($urandom_range(0, 1)) tick;
            WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == int'(len)); WVALID = 1; #1;
            check("wready", 32'(WREADY), 1);
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) ref_mem[w][b*8 +: 8] = wdat[i][b*8 +: 8];
            w++;
            tick; WVALID = 0; WLAST = 0; #1;
        end
        n = 0;
        while (!BVALID && n < 50) begin tick; #1; n++; end
        check("bvalid", 32'(BVALID), 1);
        check("bid", 32'(BID), 32'(id));
        check("bresp", 32'(BRESP), err ? 32'd2 : 32'd0);
        tick; #1;
        check("bvalid_hold", 32'(BVALID), 1);
        BREADY = 1; tick; BREADY = 0; #1;
        check("bvalid_clear", 32'(BVALID), 0);
    endtask

    initial begin
        int c0;
        logic [31:0] d0, d1, a;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) tick;
        #1;
        check("rst_arready", 32'(ARREADY), 0);
        check("rst_awready", 32'(AWREADY), 0);
        check("rst_rvalid", 32'(RVALID), 0);
        check("rst_bvalid", 32'(BVALID), 0);
        check("rst_wready", 32'(WREADY), 0);
        check("rst_cs", 32'(sram_cs), 0);
        rst = 0; tick; #1;
        check("idle_arready", 32'(ARREADY), 1);
        check("idle_awready", 32'(AWREADY), 1);

        // single read of a word written beforehand
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(8'h11, 32'h40, 0, 3'b010, 2'b01);
        do_read(8'h23, 32'h40, 0, 3'b010, 2'b01, -1, 0);

        // read burst with RREADY held low on beat 1
        do_read(8'h42, 32'h0, 3, 3'b010, 2'b01, 1, 3);

        // byte strobes over a 0xFFFFFFFF background
        wdat[0] = 32'hFFFFFFFF; wdat[1] = 32'hFFFFFFFF; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(8'h01, 32'h8, 1, 3'b010, 2'b01);
        d0 = $urandom; d1 = $urandom;
        wdat[0] = d0; wdat[1] = d1; wstb[0] = 4'b0011; wstb[1] = 4'b1111;
        do_write(8'hA7, 32'h8, 1, 3'b010, 2'b01);
        check("strb_word2", sram_mem[2], {16'hFFFF, d0[15:0]});
        check("strb_word3", sram_mem[3], d1);
        wdat[0] = $urandom; wstb[0] = 4'b0000;
        do_write(8'h02, 32'h10, 0, 3'b010, 2'b01);
        check("strb_zero", sram_mem[4], init_word(4));

        // AR/AW tie with a read that wraps past the last word
        AWID = 8'h5A; AWADDR = 32'h100; AWLEN = 0; AWVALID = 1;
        do_read(8'h66, 32'hABC0FFFF, 1, 3'b010, 2'b01, -1, 0);
        check("aw_after_rlast", 32'(AWREADY), 1);
        wdat[0] = $urandom; wstb[0] = 4'hF;
        do_write(8'h5A, 32'h100, 0, 3'b010, 2'b01);
        do_read(8'h67, 32'h100, 0, 3'b010, 2'b01, -1, 0);

        // reset during beat 1 of a 4-beat read
        ARID = 8'h77; ARADDR = 32'h200; ARLEN = 3; ARVALID = 1;
        tick; ARVALID = 0;
        tick; RREADY = 1;
        tick; RREADY = 0;
        tick; #1;
        check("mid_rvalid", 32'(RVALID), 1);
        rst = 1; #1;
        check("mid_rst_rvalid", 32'(RVALID), 0);
        check("mid_rst_arready", 32'(ARREADY), 0);
        tick; rst = 0; #1;
        check("post_rst_rvalid", 32'(RVALID), 0);
        check("post_rst_arready", 32'(ARREADY), 1);
        c0 = cs_cnt;
        repeat (4) begin
            tick; #1;
            check("post_rst_quiet", 32'(RVALID), 0);
        end
        check("post_rst_no_cs", 32'(cs_cnt - c0), 0);

        // narrow read and FIXED write: SLVERR only with the macro defined
        c0 = cs_cnt;
        do_read(8'h31, 32'h40, 1, 3'b001, 2'b01, -1, 0);
        check("slverr_rd_cs", 32'(cs_cnt - c0), is_err(3'b001, 2'b01) ? 32'd0 : 32'd2);
        c0 = cs_cnt;
        wdat[0] = $urandom; wdat[1] = $urandom; wstb[0] = 4'hF; wstb[1] = 4'hF;
        do_write(8'h32, 32'h80, 1, 3'b010, 2'b00);
        check("slverr_wr_cs", 32'(cs_cnt - c0), is_err(3'b010, 2'b00) ? 32'd0 : 32'd2);
        do_read(8'h33, 32'h80, 1, 3'b010, 2'b01, -1, 0);

        // random traffic confined to 64 words so reads observe earlier writes
        for (int t = 0; t < 24; t++) begin
            a = ($urandom & 32'hFFFF0003) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom_range(0, 15));
                end
                do_write(8'($urandom), a, 4'($urandom_range(0, 7)), 3'b010, 2'b01);
            end else begin
                do_read(8'($urandom), a, 4'($urandom_range(0, 7)), 3'b010, 2'b01,
                        $urandom_range(0, 7), $urandom_range(0, 2));
            end
        end
        do_read(8'hFE, 32'h0, 15, 3'b010, 2'b01, 15, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
